alu_uart_if: RTL and testbench

ALU_UART_IF -- requirements
Module: alu_uart_if

---
 rtl/alu_pkg.sv | 23 ++
 rtl/alu.sv | 30 +++
 rtl/alu_uart_if.sv | 97 +++++++++
 tb/tb_alu_uart_if.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU opcode constants and the state encoding of the UART/ALU bridge.
package alu_pkg;

  localparam int unsigned OP_W = 6;

  localparam logic [OP_W-1:0] OP_ADD = 6'h20;
  localparam logic [OP_W-1:0] OP_SUB = 6'h22;
  localparam logic [OP_W-1:0] OP_AND = 6'h24;
  localparam logic [OP_W-1:0] OP_OR  = 6'h25;
  localparam logic [OP_W-1:0] OP_XOR = 6'h26;
  localparam logic [OP_W-1:0] OP_SRA = 6'h03;
  localparam logic [OP_W-1:0] OP_SRL = 6'h02;
  localparam logic [OP_W-1:0] OP_NOR = 6'h27;

  typedef enum logic [2:0] {
    WAIT_A  = 3'd0,
    WAIT_B  = 3'd1,
    WAIT_OP = 3'd2,
    EXEC    = 3'd3,
    SEND    = 3'd4
  } state_t;

endpackage

// File: rtl/alu.sv
// Combinational ALU that sits beside the bridge at top level.
module alu
  import alu_pkg::*;
#(
  parameter int unsigned NB_DATA = 8,
  parameter int unsigned NB_OP   = 6
) (
  input  logic [NB_DATA-1:0] i_a,
  input  logic [NB_DATA-1:0] i_b,
  input  logic [NB_OP-1:0]   i_op,
  output logic [NB_DATA-1:0] o_result
);

  // Opcode decode; unsupported opcodes return zero.
  always_comb begin
    o_result = '0;
    case (i_op)
      NB_OP'(OP_ADD): o_result = i_a + i_b;
      NB_OP'(OP_SUB): o_result = i_a - i_b;
      NB_OP'(OP_AND): o_result = i_a & i_b;
      NB_OP'(OP_OR):  o_result = i_a | i_b;
      NB_OP'(OP_XOR): o_result = i_a ^ i_b;
      NB_OP'(OP_SRA): o_result = NB_DATA'($signed(i_a) >>> i_b);
      NB_OP'(OP_SRL): o_result = i_a >> i_b;
      NB_OP'(OP_NOR): o_result = ~(i_a | i_b);
      default:        o_result = '0;
    endcase
  end

endmodule

// File: rtl/alu_uart_if.sv
// Collects A, B and opcode bytes from the UART, latches the ALU result and
// hands it to the transmitter with a single start pulse.
module alu_uart_if
  import alu_pkg::*;
#(
  parameter int unsigned NB_DATA = 8,
  parameter int unsigned NB_OP   = 6
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_rx_valid,
  input  logic               i_tx_busy,
  input  logic [NB_DATA-1:0] i_alu_result,
  output logic [NB_DATA-1:0] o_alu_a,
  output logic [NB_DATA-1:0] o_alu_b,
  output logic [NB_OP-1:0]   o_alu_op,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_tx_start,
  output logic               o_rx_drop
);

  state_t               state, state_nxt;
  logic [NB_DATA-1:0]   a_nxt, b_nxt, tx_data_nxt;
  logic [NB_OP-1:0]     op_nxt;
  logic                 start_nxt, drop_nxt;

  // State and output registers; reset wins over any incoming byte.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= WAIT_A;
      o_alu_a    <= '0;
      o_alu_b    <= '0;
      o_alu_op   <= '0;
      o_tx_data  <= '0;
      o_tx_start <= 1'b0;
      o_rx_drop  <= 1'b0;
    end else begin
      state      <= state_nxt;
      o_alu_a    <= a_nxt;
      o_alu_b    <= b_nxt;
      o_alu_op   <= op_nxt;
      o_tx_data  <= tx_data_nxt;
      o_tx_start <= start_nxt;
      o_rx_drop  <= drop_nxt;
    end
  end

  // Next state and next register values. The start pulse is registered, so
  // the busy decision is taken one cycle ahead: at the end of EXEC, or in
  // SEND while still waiting. SEND is left in the cycle the pulse is visible.
  always_comb begin
    state_nxt   = state;
    a_nxt       = o_alu_a;
    b_nxt       = o_alu_b;
    op_nxt      = o_alu_op;
    tx_data_nxt = o_tx_data;
    start_nxt   = 1'b0;
    drop_nxt    = 1'b0;
    case (state)
      WAIT_A: begin
        if (i_rx_valid) begin
          a_nxt     = i_rx_data;
          state_nxt = WAIT_B;
        end
      end
      WAIT_B: begin
        if (i_rx_valid) begin
          b_nxt     = i_rx_data;
          state_nxt = WAIT_OP;
        end
      end
      WAIT_OP: begin
        if (i_rx_valid) begin
          op_nxt    = i_rx_data[NB_OP-1:0];
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        tx_data_nxt = i_alu_result;
        start_nxt   = ~i_tx_busy;
        drop_nxt    = i_rx_valid;
        state_nxt   = SEND;
      end
      SEND: begin
        drop_nxt = i_rx_valid;
        if (o_tx_start) begin
          state_nxt = WAIT_A;
        end else begin
          start_nxt = ~i_tx_busy;
        end
      end
      default: state_nxt = WAIT_A;
    endcase
  end

endmodule

// File: tb/tb_alu_uart_if.sv
// Scoreboard bench for the UART/ALU bridge with the real ALU attached.
module tb_alu_uart_if;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic [7:0] i_rx_data;
  logic       i_rx_valid;
  logic       i_tx_busy;
  logic [7:0] alu_result;
  logic [7:0] o_alu_a, o_alu_b, o_tx_data;
  logic [5:0] o_alu_op;
  logic       o_tx_start, o_rx_drop;

  alu_uart_if #(.NB_DATA(8), .NB_OP(6)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid),
    .i_tx_busy(i_tx_busy), .i_alu_result(alu_result), .o_alu_a(o_alu_a),
    .o_alu_b(o_alu_b), .o_alu_op(o_alu_op), .o_tx_data(o_tx_data),
    .o_tx_start(o_tx_start), .o_rx_drop(o_rx_drop)
  );

  alu #(.NB_DATA(8), .NB_OP(6)) u_alu (
    .i_a(o_alu_a), .i_b(o_alu_b), .i_op(o_alu_op), .o_result(alu_result)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [7:0] data;
    logic [7:0] a;
    logic [5:0] op;
    int         exp_cyc;
  } item_t;

  item_t sb[$];
  int    n_checks = 0;
  int    n_fail = 0;
  int    cyc = 0;
  int    drops_seen = 0;
  int    drops_exp = 0;
  int    busy_cnt = 0;
  logic  busy_force = 1'b0;
  logic  prev_start = 1'b0;
  int    last_cyc = 0;

  assign i_tx_busy = busy_force | (busy_cnt != 0);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference ALU from the opcode table, plain integer arithmetic.
  function automatic logic [7:0] model_alu(input int a, input int b, input int op);
    int sa;
    int r;
    sa = (a >= 128) ? a - 256 : a;
    case (op)
      'h20:    r = a + b;
      'h22:    r = a - b;
      'h24:    r = a & b;
      'h25:    r = a | b;
      'h26:    r = a ^ b;
      'h03:    r = (b >= 8) ? ((sa < 0) ? -1 : 0) : (sa >>> b);
      'h02:    r = (b >= 8) ? 0 : (a >> b);
      'h27:    r = ~(a | b);
      default: r = 0;
    endcase
    return 8'(r & 255);
  endfunction

  always @(posedge i_clk) cyc <= cyc + 1;

  // Transmitter model: busy for three cycles after each start.
  always @(posedge i_clk) begin
    if (o_tx_start) busy_cnt <= 3;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end

  // Monitor: pop the scoreboard on every start pulse.
  always @(negedge i_clk) begin
    item_t it;
    if (!i_rst) begin
      if (o_rx_drop) drops_seen++;
      if (o_tx_start) begin
        check("start_not_back_to_back", 32'(prev_start), 32'd0);
        if (sb.size() == 0) begin
          check("unexpected_start", 32'(o_tx_start), 32'd0);
        end else begin
          it = sb.pop_front();
          check("tx_data", 32'(o_tx_data), 32'(it.data));
          check("alu_a", 32'(o_alu_a), 32'(it.a));
          check("alu_op", 32'(o_alu_op), 32'(it.op));
          if (it.exp_cyc >= 0) check("start_cycle", 32'(cyc), 32'(it.exp_cyc));
        end
      end
    end
    prev_start = o_tx_start;
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    repeat (gap) @(negedge i_clk);
    @(negedge i_clk);
    i_rx_data  = b;
    i_rx_valid = 1'b1;
    @(posedge i_clk);
    #1;
    i_rx_valid = 1'b0;
    last_cyc   = cyc;
  endtask

  task automatic send_triple(input logic [7:0] a, input logic [7:0] b, input logic [7:0] opb,
                             input int gap, input bit chk_lat);
    item_t it;
    send_byte(a, gap);
    send_byte(b, gap);
    send_byte(opb, gap);
    it.a       = a;
    it.op      = opb[5:0];
    it.data    = model_alu(int'(a), int'(b), int'(opb[5:0]));
    it.exp_cyc = chk_lat ? last_cyc + 1 : -1;
    sb.push_back(it);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(posedge i_clk);
      n++;
    end
    check(name, 32'(sb.size()), 32'd0);
    #1;
  endtask

  initial begin
    logic [7:0] ops[8];
    logic [7:0] opb;
    ops = '{8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h03, 8'h02, 8'h27};
    i_rst = 1'b1; i_rx_valid = 1'b0; i_rx_data = '0;
    repeat (3) @(negedge i_clk);
    i_rst = 1'b0;
    @(negedge i_clk);
    check("rst_alu_a", 32'(o_alu_a), 32'd0);
    check("rst_alu_b", 32'(o_alu_b), 32'd0);
    check("rst_alu_op", 32'(o_alu_op), 32'd0);
    check("rst_tx_data", 32'(o_tx_data), 32'd0);
    check("rst_tx_start", 32'(o_tx_start), 32'd0);
    check("rst_rx_drop", 32'(o_rx_drop), 32'd0);

    // Directed: ADD with latency, SUB, SRA, SRL.
    send_triple(8'h05, 8'h03, 8'h20, 0, 1'b1); wait_idle("done_add");
    send_triple(8'h03, 8'h05, 8'h22, 0, 1'b0); wait_idle("done_sub");
    send_triple(8'h80, 8'h02, 8'h03, 1, 1'b0); wait_idle("done_sra");
    send_triple(8'h80, 8'h02, 8'h02, 2, 1'b0); wait_idle("done_srl");

    // OR held off by a busy transmitter, with a stray byte during SEND.
    repeat (4) @(negedge i_clk);
    busy_force = 1'b1;
    send_triple(8'h0F, 8'hF0, 8'h25, 0, 1'b0);
    repeat (3) @(negedge i_clk);
    send_byte(8'h55, 0);
    drops_exp++;
    repeat (5) @(negedge i_clk);
    busy_force = 1'b0;
    sb[sb.size()-1].exp_cyc = cyc + 1;
    wait_idle("done_or_busy");

    // Stray byte during EXEC.
    send_triple(8'h21, 8'h12, 8'h26, 0, 1'b1);
    send_byte(8'h55, 0);
    drops_exp++;
    wait_idle("done_xor_drop");
    repeat (3) @(negedge i_clk);
    check("drops_after_extra", 32'(drops_seen), 32'(drops_exp));

    // Reset mid-sequence, with a byte arriving in the reset cycle.
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    @(negedge i_clk);
    i_rst = 1'b1; i_rx_valid = 1'b1; i_rx_data = 8'h77;
    @(negedge i_clk);
    i_rst = 1'b0; i_rx_valid = 1'b0;
    check("midrst_alu_a", 32'(o_alu_a), 32'd0);
    check("midrst_alu_b", 32'(o_alu_b), 32'd0);
    send_triple(8'h01, 8'h01, 8'h20, 0, 1'b1); wait_idle("done_after_rst");

    // Unsupported opcode after truncation.
    send_triple(8'h3C, 8'h5A, 8'hFF, 0, 1'b1); wait_idle("done_unsupported");

    // Randomized triples.
    for (int i = 0; i < 24; i++) begin
      opb = ($urandom_range(0, 3) == 0) ? 8'($urandom) : ops[$urandom_range(0, 7)];
      send_triple(8'($urandom), 8'($urandom_range(0, 9)), opb, $urandom_range(0, 3), 1'b0);
      wait_idle("done_random");
    end

    repeat (5) @(negedge i_clk);
    check("total_drops", 32'(drops_seen), 32'(drops_exp));
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
